// File: rtl/uart_rx_conditioner.sv
// Receive-line conditioner for a board UART: two-flop synchroniser, run-length
// glitch filter, start-edge pulse, break and idle detection on the filtered line.
module uart_rx_conditioner #(
  parameter int FILTER_LEN   = 4,
  parameter int BREAK_CYCLES = 20000,
  parameter int IDLE_CYCLES  = 2000,
  parameter int CNT_W        = 16
) (
  input  logic clock,
  input  logic rst_l,
  input  logic rxd_async,
  output logic rxd,
  output logic fall_pulse,
  output logic break_pulse,
  output logic break_active,
  output logic idle
);

  localparam logic [3:0]       FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] BRK_MAX   = CNT_W'(BREAK_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_CYCLES);

  logic             s1, s2;
  logic [3:0]       fcnt;
  logic             rxd_d;
  logic [CNT_W-1:0] lcnt, hcnt;
  logic             brk_hit;

  // Synchroniser resets to the idle (mark) level so reset release never looks
  // like a start bit.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking here would collapse s1->s2 into a single stage.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rxd_async;
      s2 <= s1;
    end
  end

  // Filter: rxd follows s2 only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      rxd  <= 1'b1;
      fcnt <= '0;
    end else if (s2 == rxd) begin
      fcnt <= '0;
    end else if (fcnt == FILT_LAST) begin
      rxd  <= s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // Falling-edge detect on the filtered line; idle clears on the same edge
  // because hcnt also reacts to the first low cycle of rxd.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      rxd_d      <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      rxd_d      <= rxd;
      fall_pulse <= rxd_d & ~rxd;
    end
  end

  assign brk_hit = ~rxd && (lcnt == BRK_MAX - 1'b1);

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      lcnt         <= '0;
      break_pulse  <= 1'b0;
      break_active <= 1'b0;
    end else begin
      break_pulse <= brk_hit;
      if (rxd) begin
        lcnt         <= '0;
        break_active <= 1'b0;
      end else begin
        // Saturation at BRK_MAX is what suppresses a second pulse in one break.
        if (lcnt != BRK_MAX) lcnt <= lcnt + 1'b1;
        if (brk_hit) break_active <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      hcnt <= '0;
    end else if (!rxd) begin
      hcnt <= '0;
    end else if (hcnt != IDLE_MAX) begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign idle = (hcnt == IDLE_MAX);

endmodule

// File: tb/tb_uart_rx_conditioner.sv
// Scoreboard bench: stimulus pushes expected output events with the clock edge
// they must occur on; a negedge monitor pops and compares every observed event.
module tb_uart_rx_conditioner;

  typedef enum logic [2:0] {
    EV_RXD_FALL, EV_RXD_RISE, EV_FALL_PULSE, EV_BREAK_PULSE,
    EV_BRK_SET, EV_BRK_CLR, EV_IDLE_SET, EV_IDLE_CLR
  } ev_e;

  typedef struct {
    ev_e         kind;
    int unsigned cycle;
  } exp_t;

  logic clock, rst_l, rxd_async;
  logic rxd, fall_pulse, break_pulse, break_active, idle;

  int unsigned edge_cnt = 0;
  int          vectors  = 0;
  int          errors   = 0;
  exp_t        sb[$];

  uart_rx_conditioner #(
    .FILTER_LEN(4), .BREAK_CYCLES(64), .IDLE_CYCLES(16), .CNT_W(8)
  ) dut (
    .clock(clock), .rst_l(rst_l), .rxd_async(rxd_async),
    .rxd(rxd), .fall_pulse(fall_pulse), .break_pulse(break_pulse),
    .break_active(break_active), .idle(idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  task automatic expect_ev(input ev_e kind, input int unsigned cycle);
    exp_t e;
    e.kind  = kind;
    e.cycle = cycle;
    sb.push_back(e);
  endtask

  task automatic observe(input ev_e kind);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s at edge %0d, expected none", kind.name(), edge_cnt);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cycle != edge_cnt) begin
        errors++;
        $display("FAIL event_order: got %s at edge %0d, expected %s at edge %0d",
                 kind.name(), edge_cnt, e.kind.name(), e.cycle);
      end
    end
  endtask

  // Monitor: event order within one cycle is rxd, fall, break, break_active, idle.
  logic p_rxd, p_ba, p_idle;
  always @(negedge clock) begin
    if (rst_l) begin
      if (rxd != p_rxd)       observe(rxd ? EV_RXD_RISE : EV_RXD_FALL);
      if (fall_pulse)         observe(EV_FALL_PULSE);
      if (break_pulse)        observe(EV_BREAK_PULSE);
      if (break_active != p_ba) observe(break_active ? EV_BRK_SET : EV_BRK_CLR);
      if (idle != p_idle)     observe(idle ? EV_IDLE_SET : EV_IDLE_CLR);
    end
    p_rxd  = rxd;
    p_ba   = break_active;
    p_idle = idle;
  end

  task automatic wait_until(input int unsigned e);
    while (edge_cnt < e) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_rxd"},          int'(rxd),          1);
    check({tag, "_fall_pulse"},   int'(fall_pulse),   0);
    check({tag, "_break_pulse"},  int'(break_pulse),  0);
    check({tag, "_break_active"}, int'(break_active), 0);
    check({tag, "_idle"},         int'(idle),         0);
  endtask

  int unsigned b;

  initial begin
    rst_l     = 1'b0;
    rxd_async = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");

    // Release with pin high: idle on the 16th edge, nothing else.
    @(negedge clock);
    rst_l = 1'b1;
    b = edge_cnt;
    expect_ev(EV_IDLE_SET, b + 16);
    wait_until(b + 20);

    // 3-cycle low glitch is rejected.
    b = edge_cnt;
    rxd_async = 1'b0;
    wait_until(b + 3);
    rxd_async = 1'b1;
    wait_until(b + 15);

    // Exactly FILTER_LEN low samples do pass through, then recover.
    b = edge_cnt;
    rxd_async = 1'b0;
    expect_ev(EV_RXD_FALL,   b + 6);
    expect_ev(EV_FALL_PULSE, b + 7);
    expect_ev(EV_IDLE_CLR,   b + 7);
    expect_ev(EV_RXD_RISE,   b + 10);
    expect_ev(EV_IDLE_SET,   b + 26);
    wait_until(b + 4);
    rxd_async = 1'b1;
    wait_until(b + 30);

    // Sustained low for 100 cycles: fall, break after 64 low cycles, recovery.
    b = edge_cnt;
    rxd_async = 1'b0;
    expect_ev(EV_RXD_FALL,    b + 6);
    expect_ev(EV_FALL_PULSE,  b + 7);
    expect_ev(EV_IDLE_CLR,    b + 7);
    expect_ev(EV_BREAK_PULSE, b + 70);
    expect_ev(EV_BRK_SET,     b + 70);
    expect_ev(EV_RXD_RISE,    b + 106);
    expect_ev(EV_BRK_CLR,     b + 107);
    expect_ev(EV_IDLE_SET,    b + 122);
    wait_until(b + 100);
    rxd_async = 1'b1;
    wait_until(b + 130);

    // Reset in the middle of a break (lcnt = 40), pin kept low.
    b = edge_cnt;
    rxd_async = 1'b0;
    expect_ev(EV_RXD_FALL,   b + 6);
    expect_ev(EV_FALL_PULSE, b + 7);
    expect_ev(EV_IDLE_CLR,   b + 7);
    wait_until(b + 46);
    rst_l = 1'b0;
    check_reset_outputs("mid_break_rst");
    repeat (3) @(negedge clock);
    rst_l = 1'b1;
    b = edge_cnt;
    expect_ev(EV_RXD_FALL,    b + 6);
    expect_ev(EV_FALL_PULSE,  b + 7);
    expect_ev(EV_BREAK_PULSE, b + 70);
    expect_ev(EV_BRK_SET,     b + 70);
    expect_ev(EV_RXD_RISE,    b + 86);
    expect_ev(EV_BRK_CLR,     b + 87);
    expect_ev(EV_IDLE_SET,    b + 102);
    wait_until(b + 80);
    rxd_async = 1'b1;
    wait_until(b + 110);

    // 200 cycles of single-cycle toggles: no output activity at all.
    for (int i = 0; i < 200; i++) begin
      rxd_async = ~rxd_async;
      @(negedge clock);
    end
    rxd_async = 1'b1;
    repeat (10) @(negedge clock);

    check("pending_events", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_conditioner.md
UART_RX_CONDITIONER -- requirements
Module: uart_rx_conditioner

Purpose: board-level UART receive-line conditioner in front of the core UART rxd input. Provides synchronisation, glitch filtering, start-edge, break and idle detection.

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, legal 1..15: consecutive synchronised samples required before the filtered line changes.
REQ-002 SHALL have parameter BREAK_CYCLES, default 20000: consecutive low cycles that constitute a break.
REQ-003 SHALL have parameter IDLE_CYCLES, default 2000: consecutive high cycles that constitute idle.
REQ-004 SHALL have parameter CNT_W, default 16, with BREAK_CYCLES and IDLE_CYCLES both in 1..2^CNT_W-1; other values are illegal.
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 rst_l  in  1  asynchronous, active-low reset.
REQ-007 rxd_async  in  1  raw pin from board UART transmitter; asynchronous to clock.
REQ-008 rxd  out  1  filtered, synchronised line fed to core UART receive input.
REQ-009 fall_pulse  out  1  one-cycle pulse on each filtered 1->0 transition (start-bit candidate).
REQ-010 break_pulse  out  1  one-cycle pulse when a break is first detected.
REQ-011 break_active  out  1  level; break in progress.
REQ-012 idle  out  1  level; line has been high for at least IDLE_CYCLES.

Function
REQ-013 Synchroniser: SHALL pass rxd_async through two flops s1->s2, both resetting to 1; s2 SHALL be the only consumer of the pin.
REQ-014 Filter state: SHALL contain a 4-bit counter fcnt. If s2==rxd, fcnt<=0. If s2!=rxd and fcnt==FILTER_LEN-1, then rxd<=s2 and fcnt<=0. Otherwise fcnt<=fcnt+1.
REQ-015 Latency: a clean pin change SHALL reach rxd on the (FILTER_LEN+2)th rising edge, counting the edge that first samples the new pin value as edge 1. Default latency is edge 6.
REQ-016 Glitch rejection: an s2 deviation lasting fewer than FILTER_LEN cycles SHALL NOT change rxd. Any return of s2 to rxd value SHALL restart the count from 0.
REQ-017 fall_pulse SHALL be registered and high for exactly the one cycle following the edge on which rxd goes 1->0. It SHALL never assert on a 0->1 transition.
REQ-018 Low counter lcnt (CNT_W bits) SHALL clear while rxd==1 and increment while rxd==0, saturating at BREAK_CYCLES.
REQ-019 break_pulse SHALL assert for one cycle, and break_active SHALL set, on the edge where lcnt becomes BREAK_CYCLES. No further break_pulse SHALL occur until rxd has returned to 1.
REQ-020 break_active SHALL clear on the edge after rxd becomes 1.
REQ-021 High counter hcnt (CNT_W bits) SHALL clear while rxd==0 and increment while rxd==1, saturating at IDLE_CYCLES. idle SHALL be 1 exactly while hcnt==IDLE_CYCLES.
REQ-022 Simultaneous events: a falling rxd edge SHALL clear idle and produce fall_pulse in the same following cycle.
REQ-023 Mid-operation reset: reset asserted during a filter count, break or idle SHALL abandon all state immediately, with no pulse emitted.
REQ-024 The block SHALL contain no combinational path from rxd_async to any output.

Reset
REQ-025 While rst_l==0: s1=s2=rxd=1, fcnt=lcnt=hcnt=0, fall_pulse=break_pulse=break_active=idle=0.
REQ-026 Reset deassertion SHALL be consumed asynchronously, with no ordering requirement relative to rxd_async. After release with pin high, idle SHALL rise on the IDLE_CYCLES-th edge.

Verification (bench parameters: FILTER_LEN=4, BREAK_CYCLES=64, IDLE_CYCLES=16, CNT_W=8)
REQ-027 Release reset with pin high for 20 cycles -> rxd=1 throughout, idle=1 from edge 16, no pulses.
REQ-028 Drive pin low for 3 cycles, then high -> rxd stays 1, fall_pulse never asserts, idle stays 1.
REQ-029 Drive pin low at edge 1 and hold -> rxd=0 at edge 6, fall_pulse=1 only in cycle 7, idle=0 from cycle 7.
REQ-030 Hold pin low for 100 cycles, then high -> break_pulse exactly once, 64 cycles after rxd fell. break_active stays 1 until the cycle after rxd returns to 1.
REQ-031 Assert rst_l low mid-break (lcnt=40), release, keep pin low -> all outputs 0 during reset. rxd falls 6 edges after release with fall_pulse. break_pulse follows 64 cycles after that fall.
REQ-032 Drive alternating 1-cycle pin toggles for 200 cycles -> rxd constant, zero pulses.
